uart_rx_drain: RTL and testbench
================================

# uart_rx_drain

Controller that sequences the UART receiver: watches its byte-ready flag, captures byte plus status, acknowledges through the read strobe, and buffers accepted bytes in a small FIFO for a downstream valid/ready consumer. Also counts parity errors, receiver overwrites and FIFO overflows. Sits between `uart_rx` and any byte-stream consumer, such as a command parser.

## Interface
- `DATA_LEN`, 8: byte width; must match `uart_rx`.
- `FIFO_DEPTH`, 16: entries, power of two, 2..256.
- `DROP_BAD`, 1: 1 discards parity-error bytes; 0 stores them with the error flag.
- `ACK_TIMEOUT`, 15: max cycles in WAIT_CLR before flagging a stuck receiver.
- `CNT_W`, 8: error counter width; counters saturate.

Ports:
- `clk` in 1: single clock, shared with `uart_rx`.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: 0 stops new captures; a handshake already in progress completes.
- `clr_cnt` in 1: 1-cycle pulse, zeroes all counters.
- `rx_data` in DATA_LEN: `uart_rx.out_data`.
- `rx_ready` in 1: `uart_rx.data_ready`, a level.
- `rx_overwritten` in 1: `uart_rx.overwritten`.
- `rx_parity_err` in 1: `uart_rx.parity_error`.
- `rx_read` out 1: drives `uart_rx.data_readed`; 1-cycle pulse.
- `m_data` out DATA_LEN: FIFO head byte.
- `m_err` out 1: parity flag of the head entry (always 0 when DROP_BAD=1).
- `m_valid` out 1: FIFO not empty.
- `m_ready` in 1: consumer accepts the head when `m_valid` and `m_ready` are both high.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current occupancy.
- `par_cnt`, `ovw_cnt`, `ovf_cnt` out CNT_W: parity, overwrite and overflow counts.
- `stuck` out 1: sticky; set on ACK timeout, cleared by `rst` or `clr_cnt`.

## Operation
- State machine IDLE, CAPTURE, ACK, WAIT_CLR.
- IDLE: if `enable` and `rx_ready`, go to CAPTURE.
- CAPTURE (1 cycle): latch `rx_data`, `rx_parity_err` and `rx_overwritten`, then apply these in order:
  - if `rx_overwritten`, increment `ovw_cnt`;
  - if parity error and DROP_BAD, increment `par_cnt` and do not write;
  - if parity error and not DROP_BAD, increment `par_cnt` and write with err=1;
  - otherwise write if the FIFO is not full;
  - if the FIFO is full, increment `ovf_cnt` and drop the byte.
  - Then go to ACK.
- ACK (1 cycle): `rx_read`=1, then go to WAIT_CLR.
- WAIT_CLR: go to IDLE when `rx_ready`=0.
  - Timer counts cycles in this state. When it reaches ACK_TIMEOUT, set `stuck` and go to IDLE.
  - A later IDLE that still sees `rx_ready` recaptures; this is accepted.
- FIFO:
  - Write and pop in the same cycle are both honoured, including when full. A write to a full FIFO is an overflow even if a pop occurs in that same cycle; the decision uses registered `full`.
  - Pop while empty is ignored.
  - Pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally. Full is MSBs differing with LSBs equal; empty is pointers equal.
- Counters: saturate at 2^CNT_W-1. If `clr_cnt` and an increment occur in the same cycle, `clr_cnt` wins and the result is 0.

## Timing
- Values after `rst`:
  - state IDLE;
  - `rx_read`=0, `m_valid`=0, `fifo_level`=0;
  - all counters 0, `stuck`=0;
  - `m_data` and `m_err` = 0.
- `rst` mid-handshake: aborts with no write and no `rx_read`; the FIFO is emptied.
- From `rx_ready` rising (sampled at edge N):
  - CAPTURE at N+1;
  - FIFO write and `m_valid` visible at N+2;
  - `rx_read` high during cycle N+2.
- Minimum 4 cycles per byte when `rx_ready` drops the cycle after `rx_read`. This is far below the UART byte time.
- `m_data` is combinational from the FIFO RAM head; `m_valid` is registered.
- `rx_read` is never high for more than 1 consecutive cycle.

## Structure
- Package `uart_pkg`:
  - state encoding localparams;
  - `clog2` helper;
  - shared UART defaults (DATA_LEN=8).
- Sub-module `uart_byte_fifo` (params DATA_LEN+1, FIFO_DEPTH): synchronous FIFO with level, full and empty.
- FSM, counters and timeout stay in `uart_rx_drain`.

## Test plan
- Single byte 0x49, no errors, `m_ready`=1:
  - exactly one `rx_read` pulse;
  - `m_data`=0x49, `m_err`=0;
  - counters stay 0;
  - `fifo_level` returns to 0.
- Parity error, DROP_BAD=1, byte 0x49:
  - `par_cnt`=1;
  - `m_valid` never rises;
  - `rx_read` still pulses once.
- Fill test, `m_ready`=0:
  - send 18 bytes 0x00..0x11 with FIFO_DEPTH=16: `fifo_level`=16, `ovf_cnt`=2;
  - drain: 0x00..0x0F in order.
- `rx_overwritten`=1 on a byte: `ovw_cnt`=1 and the byte is still stored.
- `rx_ready` held high after `rx_read`:
  - `stuck`=1 after ACK_TIMEOUT cycles;
  - `clr_cnt` clears `stuck` and the counters.
- `rst` asserted in ACK:
  - next cycle `rx_read`=0, `m_valid`=0;
  - a following byte 0xA5 completes normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-side blocks: defaults, drain FSM
// encoding, error counter indices and a constant-safe log2 helper.
package uart_pkg;

  localparam int UART_DATA_LEN = 8;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_CAPTURE  = 2'd1;
  localparam logic [1:0] ST_ACK      = 2'd2;
  localparam logic [1:0] ST_WAIT_CLR = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    CAPTURE  = ST_CAPTURE,
    ACK      = ST_ACK,
    WAIT_CLR = ST_WAIT_CLR
  } drain_state_e;

  localparam int CNT_PAR = 0;
  localparam int CNT_OVW = 1;
  localparam int CNT_OVF = 2;
  localparam int CNT_NUM = 3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head word is read combinationally
// and forced to zero while empty so the output is defined after reset.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   rd_en_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic                   valid_o,
  output logic                   full_o,
  output logic [clog2(DEPTH):0]  level_o
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             wr_fire, rd_fire;

  // Flags are registered, so a write while full is rejected even if a pop
  // frees a slot in the same cycle.
  assign wr_fire = wr_en_i & ~full_q;
  assign rd_fire = rd_en_i & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW + 1)'(wr_fire);
    rd_ptr_d = rd_ptr_q + (AW + 1)'(rd_fire);
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    empty_d  = (wr_ptr_d == rd_ptr_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  assign rd_data_o = empty_q ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign valid_o   = ~empty_q;
  assign full_o    = full_q;
  assign level_o   = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/uart_rx_drain.sv
// Drains bytes from uart_rx into a FIFO via a capture/ack handshake, keeping
// saturating error counters and a sticky flag for a receiver that never clears.
module uart_rx_drain
  import uart_pkg::*;
#(
  parameter int DATA_LEN    = UART_DATA_LEN,
  parameter int FIFO_DEPTH  = 16,
  parameter int DROP_BAD    = 1,
  parameter int ACK_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        clr_cnt,
  input  logic [DATA_LEN-1:0]         rx_data,
  input  logic                        rx_ready,
  input  logic                        rx_overwritten,
  input  logic                        rx_parity_err,
  output logic                        rx_read,
  output logic [DATA_LEN-1:0]         m_data,
  output logic                        m_err,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [CNT_W-1:0]            par_cnt,
  output logic [CNT_W-1:0]            ovw_cnt,
  output logic [CNT_W-1:0]            ovf_cnt,
  output logic                        stuck
);

  localparam int TMR_W = (clog2(ACK_TIMEOUT + 1) < 1) ? 1 : clog2(ACK_TIMEOUT + 1);

  drain_state_e         state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic                 stuck_q, stuck_d;
  logic [CNT_NUM-1:0]   inc;
  logic [CNT_W-1:0]     cnt_q [CNT_NUM];
  logic                 store;
  logic                 fifo_wr;
  logic                 fifo_full;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    stuck_d = stuck_q;
    inc     = '0;
    store   = 1'b0;
    fifo_wr = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && rx_ready) state_d = CAPTURE;
      end
      CAPTURE: begin
        inc[CNT_OVW] = rx_overwritten;
        if (rx_parity_err) begin
          inc[CNT_PAR] = 1'b1;
          store        = (DROP_BAD == 0);
        end else begin
          store = 1'b1;
        end
        if (store) begin
          if (fifo_full) inc[CNT_OVF] = 1'b1;
          else           fifo_wr      = 1'b1;
        end
        state_d = ACK;
      end
      ACK: begin
        timer_d = '0;
        state_d = WAIT_CLR;
      end
      WAIT_CLR: begin
        if (!rx_ready) begin
          state_d = IDLE;
        end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
          // Give up on this handshake; a re-capture of the same byte is tolerated.
          stuck_d = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr_cnt) stuck_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      stuck_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      stuck_q <= stuck_d;
    end
  end

  for (genvar gi = 0; gi < CNT_NUM; gi++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (rst || clr_cnt) begin
        cnt_q[gi] <= '0;
      end else if (inc[gi] && (cnt_q[gi] != {CNT_W{1'b1}})) begin
        cnt_q[gi] <= cnt_q[gi] + 1'b1;
      end
    end
  end

  uart_byte_fifo #(
    .WIDTH(DATA_LEN + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (fifo_wr),
    .wr_data_i ({rx_parity_err, rx_data}),
    .rd_en_i   (m_ready),
    .rd_data_o ({m_err, m_data}),
    .valid_o   (m_valid),
    .full_o    (fifo_full),
    .level_o   (fifo_level)
  );

  assign rx_read = (state_q == ACK);
  assign par_cnt = cnt_q[CNT_PAR];
  assign ovw_cnt = cnt_q[CNT_OVW];
  assign ovf_cnt = cnt_q[CNT_OVF];
  assign stuck   = stuck_q;

endmodule

// File: tb/tb_uart_rx_drain.sv
// Scoreboard bench for uart_rx_drain: a UART receiver model drives bytes,
// expected FIFO entries are queued at drive time and checked as they pop.
module tb_uart_rx_drain;

  localparam int ACK_TO = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       clr_cnt = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_ready = 1'b0;
  logic       rx_overwritten = 1'b0;
  logic       rx_parity_err = 1'b0;
  logic       rx_read;
  logic [7:0] m_data;
  logic       m_err;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic [4:0] fifo_level;
  logic [7:0] par_cnt, ovw_cnt, ovf_cnt;
  logic       stuck;

  int checks = 0;
  int failures = 0;
  int read_pulses = 0;
  logic prev_read = 1'b0;
  logic valid_seen = 1'b0;
  logic [8:0] sb [$];

  always #5 clk = ~clk;

  uart_rx_drain dut (
    .clk(clk), .rst(rst), .enable(enable), .clr_cnt(clr_cnt),
    .rx_data(rx_data), .rx_ready(rx_ready), .rx_overwritten(rx_overwritten),
    .rx_parity_err(rx_parity_err), .rx_read(rx_read), .m_data(m_data),
    .m_err(m_err), .m_valid(m_valid), .m_ready(m_ready), .fifo_level(fifo_level),
    .par_cnt(par_cnt), .ovw_cnt(ovw_cnt), .ovf_cnt(ovf_cnt), .stuck(stuck)
  );

  // Output monitor: pops the scoreboard on each accepted head and polices rx_read width.
  always @(negedge clk) begin
    logic [8:0] exp_word;
    if (rx_read) begin
      read_pulses++;
      checks++;
      if (prev_read) begin
        failures++;
        $display("FAIL rx_read_width got two consecutive high cycles want single pulse");
      end
    end
    prev_read = rx_read;
    if (m_valid) valid_seen = 1'b1;
    if (m_valid && m_ready && !rst) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected got err=%0b data=%02h want no output", m_err, m_data);
      end else begin
        exp_word = sb.pop_front();
        if ({m_err, m_data} !== exp_word) begin
          failures++;
          $display("FAIL pop_data got err=%0b data=%02h want err=%0b data=%02h",
                   m_err, m_data, exp_word[8], exp_word[7:0]);
        end else begin
          $display("pop data=%02h err=%0b", m_data, m_err);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic par, input logic ovw,
                           input logic store, output int lat);
    @(posedge clk); #1;
    rx_data = d; rx_parity_err = par; rx_overwritten = ovw; rx_ready = 1'b1;
    if (store) sb.push_back({1'b0, d});
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rx_read) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat < 0) begin
      failures++;
      $display("FAIL rx_read_timeout byte=%02h got no pulse want pulse within 20 cycles", d);
    end
    @(posedge clk); #1;
    rx_ready = 1'b0; rx_parity_err = 1'b0; rx_overwritten = 1'b0;
    $display("send data=%02h par=%0b ovw=%0b store=%0b lat=%0d", d, par, ovw, store, lat);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || fifo_level != 0) && n < 80) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0 || fifo_level != 0) begin
      failures++;
      $display("FAIL %s_drain got pending=%0d level=%0d want 0/0", name, sb.size(), fifo_level);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (rx_read !== 1'b0) begin failures++; $display("FAIL reset_rx_read got %0b want 0", rx_read); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got %0b want 0", m_valid); end
    checks++; if (fifo_level !== 5'd0) begin failures++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    checks++; if ({par_cnt, ovw_cnt, ovf_cnt} !== 24'd0) begin failures++; $display("FAIL reset_counters got %0d/%0d/%0d want 0/0/0", par_cnt, ovw_cnt, ovf_cnt); end
    checks++; if (stuck !== 1'b0) begin failures++; $display("FAIL reset_stuck got %0b want 0", stuck); end
    checks++; if ({m_err, m_data} !== 9'd0) begin failures++; $display("FAIL reset_head got %03h want 000", {m_err, m_data}); end
    rst = 1'b0;
    $display("reset done");
  endtask

  task automatic test_single();
    int lat;
    int p0;
    m_ready = 1'b1;
    p0 = read_pulses;
    @(posedge clk); #1;
    rx_data = 8'h49; rx_ready = 1'b1;
    sb.push_back({1'b0, 8'h49});
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rx_read) begin lat = i; break; end
    end
    checks++; if (lat != 2) begin failures++; $display("FAIL single_latency got %0d want 2", lat); end
    checks++; if (m_valid !== 1'b1 || m_data !== 8'h49 || m_err !== 1'b0) begin failures++; $display("FAIL single_head got v=%0b d=%02h e=%0b want v=1 d=49 e=0", m_valid, m_data, m_err); end
    @(posedge clk); #1; rx_ready = 1'b0;
    repeat (4) @(negedge clk);
    wait_drain("single");
    checks++; if (read_pulses - p0 != 1) begin failures++; $display("FAIL single_pulses got %0d want 1", read_pulses - p0); end
    checks++; if ({par_cnt, ovw_cnt, ovf_cnt} !== 24'd0) begin failures++; $display("FAIL single_counters got %0d/%0d/%0d want 0/0/0", par_cnt, ovw_cnt, ovf_cnt); end
  endtask

  task automatic test_parity();
    int lat;
    int p0;
    p0 = read_pulses;
    valid_seen = 1'b0;
    send_byte(8'h49, 1'b1, 1'b0, 1'b0, lat);
    repeat (4) @(negedge clk);
    checks++; if (par_cnt !== 8'd1) begin failures++; $display("FAIL parity_cnt got %0d want 1", par_cnt); end
    checks++; if (valid_seen !== 1'b0) begin failures++; $display("FAIL parity_valid got %0b want 0", valid_seen); end
    checks++; if (read_pulses - p0 != 1) begin failures++; $display("FAIL parity_pulses got %0d want 1", read_pulses - p0); end
  endtask

  task automatic test_overwrite();
    int lat;
    send_byte(8'h3C, 1'b0, 1'b1, 1'b1, lat);
    repeat (3) @(negedge clk);
    wait_drain("overwrite");
    checks++; if (ovw_cnt !== 8'd1) begin failures++; $display("FAIL overwrite_cnt got %0d want 1", ovw_cnt); end
  endtask

  task automatic test_fill();
    int lat;
    m_ready = 1'b0;
    for (int i = 0; i < 18; i++) send_byte(8'(i), 1'b0, 1'b0, (i < 16), lat);
    repeat (3) @(negedge clk);
    checks++; if (fifo_level !== 5'd16) begin failures++; $display("FAIL fill_level got %0d want 16", fifo_level); end
    checks++; if (ovf_cnt !== 8'd2) begin failures++; $display("FAIL fill_ovf got %0d want 2", ovf_cnt); end
    @(posedge clk); #1; m_ready = 1'b1;
    wait_drain("fill");
  endtask

  task automatic test_stuck();
    int p0;
    int lat;
    p0 = read_pulses;
    @(posedge clk); #1;
    rx_data = 8'h5A; rx_ready = 1'b1;
    sb.push_back({1'b0, 8'h5A});
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rx_read) begin lat = i; break; end
    end
    checks++; if (lat < 0) begin failures++; $display("FAIL stuck_rx_read got no pulse want pulse"); end
    @(posedge clk); #1; enable = 1'b0;
    repeat (ACK_TO - 3) @(negedge clk);
    checks++; if (stuck !== 1'b0) begin failures++; $display("FAIL stuck_early got %0b want 0", stuck); end
    repeat (6) @(negedge clk);
    checks++; if (stuck !== 1'b1) begin failures++; $display("FAIL stuck_set got %0b want 1", stuck); end
    checks++; if (read_pulses - p0 != 1) begin failures++; $display("FAIL stuck_pulses got %0d want 1", read_pulses - p0); end
    rx_ready = 1'b0; enable = 1'b1; clr_cnt = 1'b1;
    @(negedge clk); clr_cnt = 1'b0;
    checks++; if (stuck !== 1'b0) begin failures++; $display("FAIL stuck_clear got %0b want 0", stuck); end
    checks++; if ({par_cnt, ovw_cnt, ovf_cnt} !== 24'd0) begin failures++; $display("FAIL clr_counters got %0d/%0d/%0d want 0/0/0", par_cnt, ovw_cnt, ovf_cnt); end
    wait_drain("stuck");
  endtask

  task automatic test_rst_in_ack();
    int lat;
    int seen;
    m_ready = 1'b0;
    @(posedge clk); #1;
    rx_data = 8'h77; rx_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rx_read) begin seen = 1; break; end
    end
    checks++; if (seen == 0) begin failures++; $display("FAIL ackrst_rx_read got no pulse want pulse"); end
    rst = 1'b1; rx_ready = 1'b0;
    @(negedge clk);
    checks++; if (rx_read !== 1'b0) begin failures++; $display("FAIL ackrst_rx_read got %0b want 0", rx_read); end
    checks++; if (m_valid !== 1'b0 || fifo_level !== 5'd0) begin failures++; $display("FAIL ackrst_fifo got v=%0b lvl=%0d want 0/0", m_valid, fifo_level); end
    rst = 1'b0; m_ready = 1'b1;
    send_byte(8'hA5, 1'b0, 1'b0, 1'b1, lat);
    checks++; if (lat != 2) begin failures++; $display("FAIL ackrst_latency got %0d want 2", lat); end
    wait_drain("ackrst");
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_overwrite();
    test_fill();
    test_stuck();
    test_rst_in_ack();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL final_scoreboard got %0d pending want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
